fetch_wide: RTL and testbench
=============================

# fetch_wide

Parametrised multi-lane fetch unit: issues aligned fetch-block requests to the instruction memory/MMU path, tracks outstanding requests in an in-order address queue, and forwards returned instructions to decode with lane compaction after unaligned redirects. It sits between the instruction fetch port (previous) and the decoder/loop buffer (next), and generalises the 2-instruction fetch stage to P_LANES instructions per cycle.

## Interface
- P_LANES, 2, instructions per fetch block; power of two, 2..8
- P_LANE_N, 1, log2(P_LANES)
- P_QUEUE_DEPTH, 8, outstanding-request queue entries; power of two
- P_QUEUE_DEPTH_N, 3, log2(P_QUEUE_DEPTH)
- iCLOCK  in  1  clock
- iRESET  in  1  reset; asynchronous, active-high
- iEXCEPTION_INST_DISCARD  in  1  drop returning instructions this cycle
- iEXCEPTION_EVENT  in  1  redirect start; flush all
- iEXCEPTION_ADDR_SET  in  1  iEXCEPTION_ADDR valid
- iEXCEPTION_ADDR  in  32  redirect target (byte address)
- iEXCEPTION_RESTART  in  1  resume fetching at target
- iFETCH_STOP_LOOPBUFFER_LIMIT  in  1  suppress new requests
- iPREVIOUS_INST_VALID  in  P_LANES  per-lane returned-valid
- iPREVIOUS_MMU_FLAGS  in  6*P_LANES  per-lane flags, lane k at [6k+5:6k]
- iPREVIOUS_INST  in  32*P_LANES  per-lane instruction, lane k at [32k+31:32k]
- oPREVIOUS_LOCK  out  1  back-pressure to fetch return path
- oPREVIOUS_FETCH_REQ  out  1  fetch request strobe
- oPREVIOUS_FETCH_ADDR  out  32  block-aligned request address
- iPREVIOUS_FETCH_LOCK  in  1  request path busy
- oNEXT_INST_VALID  out  P_LANES  per-lane output valid
- oNEXT_MMU_FLAGS  out  6*P_LANES  per-lane flags
- oNEXT_INST  out  32*P_LANES  per-lane instructions
- oNEXT_PC  out  32  byte address of output lane 0
- iNEXT_LOCK  in  1  decoder stall
- oSTAT_FETCH_COUNT  out  32  see Configuration
- oSTAT_STALL_COUNT  out  32  see Configuration

## Operation
- Block size B = 4*P_LANES bytes. All request addresses aligned to B.
- FSM: RESET_START -> FETCH (unconditional, pc=0, offset=0). FETCH -> WAIT_RESTART on iEXCEPTION_EVENT. WAIT_RESTART -> FETCH when iEXCEPTION_ADDR_SET && iEXCEPTION_RESTART && !iEXCEPTION_EVENT; pc = iEXCEPTION_ADDR aligned down to B, offset = iEXCEPTION_ADDR[P_LANE_N+1:2].
- Request: oPREVIOUS_FETCH_REQ = state==FETCH && !iEXCEPTION_EVENT && !queue_full && !iPREVIOUS_FETCH_LOCK && !iFETCH_STOP_LOOPBUFFER_LIMIT. On request: push {pc, offset} to queue, pc += B (mod 2^32 wrap), offset = 0.
- Return: blocks return in request order. A return cycle (any iPREVIOUS_INST_VALID bit set, !iNEXT_LOCK, !iEXCEPTION_INST_DISCARD) pops the queue head {addr, off}.
- Compaction: output lane j = input lane j+off; lanes j >= P_LANES-off invalid. oNEXT_PC = addr + 4*off.
- Output valid lane j = registered valid && input valid of source lane && !iEXCEPTION_INST_DISCARD; all oNEXT_INST_VALID forced 0 while iNEXT_LOCK.
- oPREVIOUS_LOCK = iEXCEPTION_INST_DISCARD ? 0 : iNEXT_LOCK.
- iEXCEPTION_EVENT: output registers cleared, queue flushed, no request that cycle. Event with restart same cycle: event wins; restart must be re-presented.
- Queue full: no request, pc held. Queue empty with return valid: protocol error; output captured, oNEXT_PC undefined.

## Timing
- Reset values: all outputs 0 (oNEXT_* zero, oPREVIOUS_FETCH_REQ 0, oPREVIOUS_LOCK follows inputs, counters 0).
- Reset release: first request (addr 0) asserted after second rising edge (RESET_START then FETCH).
- Restart accepted at edge t: request with new aligned address visible in cycle after t.
- Return captured at edge t: oNEXT_* valid in cycle after t. Output registers hold while iNEXT_LOCK.
- Push and pop same cycle when full: push blocked (full sampled before pop).
- Reset mid-operation: immediate clear of FSM, queue, outputs.

## Configuration
- FETCH_WIDE_STAT_EN defined: oSTAT_FETCH_COUNT increments per accepted request; oSTAT_STALL_COUNT increments per cycle in FETCH with request suppressed by queue_full or iPREVIOUS_FETCH_LOCK; both wrap, cleared by reset only.
- Not defined: both stat ports tied to 0, no counter logic.

## Test plan
- Reset release, no locks, P_LANES=2 -> requests at 0x0, 0x8, 0x10 on consecutive cycles.
- P_LANES=4, event then restart addr 0x104 -> request 0x100; returned block lanes 1..3 appear as out lanes 0..2, lane 3 invalid, oNEXT_PC=0x104.
- Never return data, P_QUEUE_DEPTH=8 -> exactly 8 requests then oPREVIOUS_FETCH_REQ held 0, pc stable; one return -> one further request.
- iNEXT_LOCK high 3 cycles with data returning -> oNEXT_INST_VALID 0, oPREVIOUS_LOCK 1, outputs resume unchanged after release.
- iEXCEPTION_EVENT and iEXCEPTION_RESTART same cycle -> stays WAIT_RESTART, no request; restart next cycle -> request at new target.
- FETCH_WIDE_STAT_EN, 5 requests and 2 lock cycles -> counters read 5 and 2; pc 0xFFFFFFF8 (P_LANES=2) wraps to 0x0.

Source files
------------

// File: rtl/fetch_wide.sv
// fetch_wide: multi-lane fetch unit with in-order request queue and lane compaction after unaligned redirects.
// Define FETCH_WIDE_STAT_EN to enable the request/stall statistics counters; otherwise both stat ports read 0.
module fetch_wide #(
    parameter int P_LANES = 2,
    parameter int P_LANE_N = 1,
    parameter int P_QUEUE_DEPTH = 8,
    parameter int P_QUEUE_DEPTH_N = 3
)(
    input  logic                   iCLOCK,
    input  logic                   iRESET,
    input  logic                   iEXCEPTION_INST_DISCARD,
    input  logic                   iEXCEPTION_EVENT,
    input  logic                   iEXCEPTION_ADDR_SET,
    input  logic [31:0]            iEXCEPTION_ADDR,
    input  logic                   iEXCEPTION_RESTART,
    input  logic                   iFETCH_STOP_LOOPBUFFER_LIMIT,
    input  logic [P_LANES-1:0]     iPREVIOUS_INST_VALID,
    input  logic [6*P_LANES-1:0]   iPREVIOUS_MMU_FLAGS,
    input  logic [32*P_LANES-1:0]  iPREVIOUS_INST,
    output logic                   oPREVIOUS_LOCK,
    output logic                   oPREVIOUS_FETCH_REQ,
    output logic [31:0]            oPREVIOUS_FETCH_ADDR,
    input  logic                   iPREVIOUS_FETCH_LOCK,
    output logic [P_LANES-1:0]     oNEXT_INST_VALID,
    output logic [6*P_LANES-1:0]   oNEXT_MMU_FLAGS,
    output logic [32*P_LANES-1:0]  oNEXT_INST,
    output logic [31:0]            oNEXT_PC,
    input  logic                   iNEXT_LOCK,
    output logic [31:0]            oSTAT_FETCH_COUNT,
    output logic [31:0]            oSTAT_STALL_COUNT
);
    localparam int B = 4 * P_LANES;

    typedef enum logic [1:0] {RESET_START, FETCH, WAIT_RESTART} state_t;

    state_t                     state;
    logic [31:0]                pc;
    logic [P_LANE_N-1:0]        offset;
    logic [31:0]                q_addr [P_QUEUE_DEPTH];
    logic [P_LANE_N-1:0]        q_off [P_QUEUE_DEPTH];
    logic [P_QUEUE_DEPTH_N-1:0] wr_ptr, rd_ptr;
    logic [P_QUEUE_DEPTH_N:0]   count;
    logic                       full, req, ret, pop, restart_ok;
    logic [31:0]                head_addr;
    logic [P_LANE_N-1:0]        head_off;
    logic [P_LANES-1:0]         cmp_valid, valid_r;
    logic [6*P_LANES-1:0]       cmp_flags, flags_r;
    logic [32*P_LANES-1:0]      cmp_inst, inst_r;
    logic [31:0]                pc_r;
    logic                       unused_addr_bits;

    assign unused_addr_bits = ^iEXCEPTION_ADDR[1:0];
    assign full = count == (P_QUEUE_DEPTH_N+1)'(P_QUEUE_DEPTH);
    assign req = state == FETCH && !iEXCEPTION_EVENT && !full && !iPREVIOUS_FETCH_LOCK && !iFETCH_STOP_LOOPBUFFER_LIMIT;
    assign ret = |iPREVIOUS_INST_VALID && !iNEXT_LOCK && !iEXCEPTION_INST_DISCARD;
    assign pop = ret && count != '0;
    assign restart_ok = iEXCEPTION_ADDR_SET && iEXCEPTION_RESTART && !iEXCEPTION_EVENT;
    assign head_addr = q_addr[rd_ptr];
    assign head_off = q_off[rd_ptr];

    assign oPREVIOUS_FETCH_REQ = req;
    assign oPREVIOUS_FETCH_ADDR = pc;
    assign oPREVIOUS_LOCK = iEXCEPTION_INST_DISCARD ? 1'b0 : iNEXT_LOCK;
    assign oNEXT_INST_VALID = iNEXT_LOCK ? '0 : valid_r;
    assign oNEXT_MMU_FLAGS = flags_r;
    assign oNEXT_INST = inst_r;
    assign oNEXT_PC = pc_r;

    // Shift the returned block down by the head entry's lane offset
    always_comb begin
        cmp_valid = '0;
        cmp_flags = '0;
        cmp_inst = '0;
        for (int j = 0; j < P_LANES; j++) begin
            if (j + int'(head_off) < P_LANES) begin
                cmp_valid[j] = iPREVIOUS_INST_VALID[j + int'(head_off)];
                cmp_flags[6*j +: 6] = iPREVIOUS_MMU_FLAGS[6*(j + int'(head_off)) +: 6];
                cmp_inst[32*j +: 32] = iPREVIOUS_INST[32*(j + int'(head_off)) +: 32];
            end
        end
    end

    // Fetch FSM, request pc and queue pointers; an exception flushes the queue
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state <= RESET_START;
            pc <= '0;
            offset <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (state == RESET_START) begin
                state <= FETCH;
                pc <= '0;
                offset <= '0;
            end else if (state == FETCH && iEXCEPTION_EVENT) begin
                state <= WAIT_RESTART;
            end else if (state == WAIT_RESTART && restart_ok) begin
                state <= FETCH;
                pc <= {iEXCEPTION_ADDR[31:P_LANE_N+2], {(P_LANE_N+2){1'b0}}};
                offset <= iEXCEPTION_ADDR[P_LANE_N+1:2];
            end else if (req) begin
                pc <= pc + 32'(B);
                offset <= '0;
            end
            if (iEXCEPTION_EVENT) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count <= '0;
            end else begin
                if (req) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + (P_QUEUE_DEPTH_N+1)'(req) - (P_QUEUE_DEPTH_N+1)'(pop);
            end
        end
    end

    // Queue storage: block address and the lane offset of the first wanted instruction
    always_ff @(posedge iCLOCK) begin
        if (req) begin
            q_addr[wr_ptr] <= pc;
            q_off[wr_ptr] <= offset;
        end
    end

    // Decode-side output registers: capture on return, hold while the decoder stalls
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET || iEXCEPTION_EVENT) begin
            valid_r <= '0;
            flags_r <= '0;
            inst_r <= '0;
            pc_r <= '0;
        end else if (!iNEXT_LOCK) begin
            valid_r <= ret ? cmp_valid : '0;
            if (ret) begin
                flags_r <= cmp_flags;
                inst_r <= cmp_inst;
                pc_r <= head_addr + {{(30-P_LANE_N){1'b0}}, head_off, 2'b00};
            end
        end
    end

`ifdef FETCH_WIDE_STAT_EN
    logic [31:0] fetch_count, stall_count;

    assign oSTAT_FETCH_COUNT = fetch_count;
    assign oSTAT_STALL_COUNT = stall_count;

    // Count accepted requests and cycles where the queue or request path held fetch back
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            fetch_count <= fetch_count + 32'(req);
            stall_count <= stall_count + 32'(state == FETCH && (full || iPREVIOUS_FETCH_LOCK));
        end
    end
`else
    assign oSTAT_FETCH_COUNT = '0;
    assign oSTAT_STALL_COUNT = '0;
`endif
endmodule

// File: tb/tb_fetch_wide.sv
// tb_fetch_wide: directed checks of fetch_wide with four lanes and an eight-entry queue.
module tb_fetch_wide;
    localparam int L = 4;

    logic            iCLOCK = 0;
    logic            iRESET = 1;
    logic            iEXCEPTION_INST_DISCARD = 0;
    logic            iEXCEPTION_EVENT = 0;
    logic            iEXCEPTION_ADDR_SET = 0;
    logic [31:0]     iEXCEPTION_ADDR = 0;
    logic            iEXCEPTION_RESTART = 0;
    logic            iFETCH_STOP_LOOPBUFFER_LIMIT = 0;
    logic [L-1:0]    iPREVIOUS_INST_VALID = 0;
    logic [6*L-1:0]  iPREVIOUS_MMU_FLAGS = 0;
    logic [32*L-1:0] iPREVIOUS_INST = 0;
    logic            oPREVIOUS_LOCK;
    logic            oPREVIOUS_FETCH_REQ;
    logic [31:0]     oPREVIOUS_FETCH_ADDR;
    logic            iPREVIOUS_FETCH_LOCK = 0;
    logic [L-1:0]    oNEXT_INST_VALID;
    logic [6*L-1:0]  oNEXT_MMU_FLAGS;
    logic [32*L-1:0] oNEXT_INST;
    logic [31:0]     oNEXT_PC;
    logic            iNEXT_LOCK = 0;
    logic [31:0]     oSTAT_FETCH_COUNT;
    logic [31:0]     oSTAT_STALL_COUNT;

    int n_checks = 0;
    int n_fail = 0;

    fetch_wide #(.P_LANES(4), .P_LANE_N(2), .P_QUEUE_DEPTH(8), .P_QUEUE_DEPTH_N(3)) dut (
        .iCLOCK(iCLOCK), .iRESET(iRESET),
        .iEXCEPTION_INST_DISCARD(iEXCEPTION_INST_DISCARD), .iEXCEPTION_EVENT(iEXCEPTION_EVENT),
        .iEXCEPTION_ADDR_SET(iEXCEPTION_ADDR_SET), .iEXCEPTION_ADDR(iEXCEPTION_ADDR),
        .iEXCEPTION_RESTART(iEXCEPTION_RESTART), .iFETCH_STOP_LOOPBUFFER_LIMIT(iFETCH_STOP_LOOPBUFFER_LIMIT),
        .iPREVIOUS_INST_VALID(iPREVIOUS_INST_VALID), .iPREVIOUS_MMU_FLAGS(iPREVIOUS_MMU_FLAGS),
        .iPREVIOUS_INST(iPREVIOUS_INST), .oPREVIOUS_LOCK(oPREVIOUS_LOCK),
        .oPREVIOUS_FETCH_REQ(oPREVIOUS_FETCH_REQ), .oPREVIOUS_FETCH_ADDR(oPREVIOUS_FETCH_ADDR),
        .iPREVIOUS_FETCH_LOCK(iPREVIOUS_FETCH_LOCK), .oNEXT_INST_VALID(oNEXT_INST_VALID),
        .oNEXT_MMU_FLAGS(oNEXT_MMU_FLAGS), .oNEXT_INST(oNEXT_INST), .oNEXT_PC(oNEXT_PC),
        .iNEXT_LOCK(iNEXT_LOCK), .oSTAT_FETCH_COUNT(oSTAT_FETCH_COUNT), .oSTAT_STALL_COUNT(oSTAT_STALL_COUNT)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_block(input logic [31:0] base, input logic [L-1:0] v);
        iPREVIOUS_INST_VALID = v;
        for (int k = 0; k < L; k++) begin
            iPREVIOUS_INST[32*k +: 32] = base + 32'(k);
            iPREVIOUS_MMU_FLAGS[6*k +: 6] = 6'(k + 10);
        end
    endtask

    initial begin
        int w;
        int nreq;
        logic [31:0] f0, s0;
        // reset values
        iNEXT_LOCK = 1;
        repeat (2) tick();
        check("rst_req", oPREVIOUS_FETCH_REQ, 0);
        check("rst_valid", oNEXT_INST_VALID, 0);
        check("rst_pc", oNEXT_PC, 0);
        check("rst_inst", oNEXT_INST, 0);
        check("rst_prev_lock", oPREVIOUS_LOCK, 1);
        check("rst_stat_fetch", oSTAT_FETCH_COUNT, 0);
        check("rst_stat_stall", oSTAT_STALL_COUNT, 0);
        iNEXT_LOCK = 0;
        settle();
        check("rst_prev_lock_low", oPREVIOUS_LOCK, 0);
        iRESET = 0;
        settle();
        check("release_no_req", oPREVIOUS_FETCH_REQ, 0);
        // consecutive requests until the queue fills
        w = 0;
        while (!oPREVIOUS_FETCH_REQ && w < 4) begin
            tick();
            w++;
        end
        check("first_req", oPREVIOUS_FETCH_REQ, 1);
        nreq = 0;
        for (int i = 0; i < 12; i++) begin
            if (oPREVIOUS_FETCH_REQ) begin
                check("req_addr", oPREVIOUS_FETCH_ADDR, 64'(32'(16 * nreq)));
                nreq++;
            end
            tick();
        end
        check("req_count_full", nreq, 8);
        check("full_no_req", oPREVIOUS_FETCH_REQ, 0);
        check("full_pc_held", oPREVIOUS_FETCH_ADDR, 32'h80);
        // one return frees one slot; push blocked in the pop cycle
        set_block(32'hA000_0000, 4'hF);
        settle();
        check("full_pop_no_push", oPREVIOUS_FETCH_REQ, 0);
        tick();
        iPREVIOUS_INST_VALID = 0;
        settle();
        check("ret_valid", oNEXT_INST_VALID, 4'hF);
        check("ret_pc", oNEXT_PC, 0);
        check("ret_lane0", oNEXT_INST[31:0], 32'hA000_0000);
        check("ret_lane3", oNEXT_INST[127:96], 32'hA000_0003);
        check("ret_flags", oNEXT_MMU_FLAGS, {6'd13, 6'd12, 6'd11, 6'd10});
        check("refill_req", oPREVIOUS_FETCH_REQ, 1);
        check("refill_addr", oPREVIOUS_FETCH_ADDR, 32'h80);
        tick();
        check("refull_no_req", oPREVIOUS_FETCH_REQ, 0);
        check("refull_addr", oPREVIOUS_FETCH_ADDR, 32'h90);
        check("valid_drops", oNEXT_INST_VALID, 0);
        // decoder stall with data returning
        set_block(32'hB000_0000, 4'hF);
        tick();
        check("blk2_pc", oNEXT_PC, 32'h10);
        iNEXT_LOCK = 1;
        set_block(32'hC000_0000, 4'hF);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("lock_valid", oNEXT_INST_VALID, 0);
            check("lock_prev_lock", oPREVIOUS_LOCK, 1);
            tick();
        end
        iEXCEPTION_INST_DISCARD = 1;
        settle();
        check("discard_prev_lock", oPREVIOUS_LOCK, 0);
        iEXCEPTION_INST_DISCARD = 0;
        iNEXT_LOCK = 0;
        iPREVIOUS_INST_VALID = 0;
        settle();
        check("unlock_valid", oNEXT_INST_VALID, 4'hF);
        check("unlock_lane0", oNEXT_INST[31:0], 32'hB000_0000);
        check("unlock_pc", oNEXT_PC, 32'h10);
        // exception with restart in the same cycle: event wins
        iEXCEPTION_EVENT = 1;
        iEXCEPTION_ADDR_SET = 1;
        iEXCEPTION_RESTART = 1;
        iEXCEPTION_ADDR = 32'h104;
        settle();
        check("event_no_req", oPREVIOUS_FETCH_REQ, 0);
        tick();
        iEXCEPTION_EVENT = 0;
        iEXCEPTION_ADDR_SET = 0;
        iEXCEPTION_RESTART = 0;
        settle();
        check("wait_no_req", oPREVIOUS_FETCH_REQ, 0);
        check("event_clr_pc", oNEXT_PC, 0);
        check("event_clr_valid", oNEXT_INST_VALID, 0);
        check("event_clr_inst", oNEXT_INST, 0);
        iEXCEPTION_EVENT = 1;
        iEXCEPTION_ADDR_SET = 1;
        iEXCEPTION_RESTART = 1;
        tick();
        iEXCEPTION_EVENT = 0;
        settle();
        check("restart_pending", oPREVIOUS_FETCH_REQ, 0);
        tick();
        iEXCEPTION_ADDR_SET = 0;
        iEXCEPTION_RESTART = 0;
        settle();
        check("restart_req", oPREVIOUS_FETCH_REQ, 1);
        check("restart_addr", oPREVIOUS_FETCH_ADDR, 32'h100);
        tick();
        iFETCH_STOP_LOOPBUFFER_LIMIT = 1;
        settle();
        check("stop_no_req", oPREVIOUS_FETCH_REQ, 0);
        check("restart_next", oPREVIOUS_FETCH_ADDR, 32'h110);
        // compaction of the unaligned block (source lane 2 invalid)
        set_block(32'hD000_0000, 4'b1011);
        tick();
        iPREVIOUS_INST_VALID = 0;
        settle();
        check("cmp_valid", oNEXT_INST_VALID, 4'b0101);
        check("cmp_pc", oNEXT_PC, 32'h104);
        check("cmp_lane0", oNEXT_INST[31:0], 32'hD000_0001);
        check("cmp_lane1", oNEXT_INST[63:32], 32'hD000_0002);
        check("cmp_lane2", oNEXT_INST[95:64], 32'hD000_0003);
        check("cmp_flags0", oNEXT_MMU_FLAGS[5:0], 6'd11);
        // statistics window and pc wrap
        f0 = oSTAT_FETCH_COUNT;
        s0 = oSTAT_STALL_COUNT;
        iEXCEPTION_EVENT = 1;
        tick();
        iEXCEPTION_EVENT = 0;
        iEXCEPTION_ADDR_SET = 1;
        iEXCEPTION_RESTART = 1;
        iEXCEPTION_ADDR = 32'hFFFF_FFE4;
        tick();
        iEXCEPTION_ADDR_SET = 0;
        iEXCEPTION_RESTART = 0;
        iFETCH_STOP_LOOPBUFFER_LIMIT = 0;
        settle();
        check("wrap_a0", oPREVIOUS_FETCH_ADDR, 32'hFFFF_FFE0);
        tick();
        check("wrap_a1", oPREVIOUS_FETCH_ADDR, 32'hFFFF_FFF0);
        tick();
        check("wrap_a2", oPREVIOUS_FETCH_ADDR, 32'h0);
        tick();
        check("wrap_a3", oPREVIOUS_FETCH_ADDR, 32'h10);
        tick();
        check("wrap_a4", oPREVIOUS_FETCH_ADDR, 32'h20);
        check("wrap_req", oPREVIOUS_FETCH_REQ, 1);
        tick();
        iPREVIOUS_FETCH_LOCK = 1;
        settle();
        check("flock_no_req", oPREVIOUS_FETCH_REQ, 0);
        repeat (2) tick();
        iPREVIOUS_FETCH_LOCK = 0;
        iFETCH_STOP_LOOPBUFFER_LIMIT = 1;
        settle();
`ifdef FETCH_WIDE_STAT_EN
        check("stat_fetch", oSTAT_FETCH_COUNT - f0, 5);
        check("stat_stall", oSTAT_STALL_COUNT - s0, 2);
`else
        check("stat_fetch_off", oSTAT_FETCH_COUNT, 0);
        check("stat_stall_off", oSTAT_STALL_COUNT, 0);
`endif
        // reset mid-operation clears everything at once
        iRESET = 1;
        settle();
        check("midrst_req", oPREVIOUS_FETCH_REQ, 0);
        check("midrst_addr", oPREVIOUS_FETCH_ADDR, 0);
        check("midrst_pc", oNEXT_PC, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
